// File: rtl/divider_processor.sv
`default_nettype none
// ============================================================================
// Module   : divider_processor
// Desc     : Shift-subtract divider, A:B / S -> quotient in B, remainder in A.
//            Define DIV_SIGNED_EN for two's-complement operation.
// Revision : 1.0
// ============================================================================
module divider_processor #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Execute,
    input  logic             LoadA,
    input  logic             LoadB,
    input  logic             LoadS,
    input  logic [WIDTH-1:0] Din,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic [WIDTH-1:0] Sval,
    output logic             Busy,
    output logic             Ovf,
    output logic [6:0]       AhexL,
    output logic [6:0]       AhexU,
    output logic [6:0]       BhexL,
    output logic [6:0]       BhexU
);

    localparam int c_NBTN = 4;
    localparam int c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int c_HW   = (WIDTH > 8) ? WIDTH : 8;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Buttons are active-low; synchronizers reset to the released level.
    logic [c_NBTN-1:0] w_btn_raw;
    logic [c_NBTN-1:0] w_btn;
    assign w_btn_raw = {LoadS, LoadB, LoadA, Execute};

    genvar gi;
    generate
        for (gi = 0; gi < c_NBTN; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] r_ff;
            if (SYNC_STAGES == 1) begin : g_one
                always_ff @(posedge Clk or negedge Reset) begin
                    if (!Reset) r_ff <= '1;
                    else        r_ff <= w_btn_raw[gi];
                end
            end else begin : g_multi
                always_ff @(posedge Clk or negedge Reset) begin
                    if (!Reset) r_ff <= '1;
                    else        r_ff <= {r_ff[SYNC_STAGES-2:0], w_btn_raw[gi]};
                end
            end
            assign w_btn[gi] = r_ff[SYNC_STAGES-1];
        end
    endgenerate

    state_t             r_state;
    logic [WIDTH-1:0]   r_a, r_b, r_s;
    logic [WIDTH-1:0]   r_rem, r_quo, r_dabs;
    logic [c_CW-1:0]    r_cnt;
    logic               r_busy, r_ovf, r_exec_d;
`ifdef DIV_SIGNED_EN
    logic               r_sn, r_sd;
`endif

    logic               w_start;
    logic [2*WIDTH-1:0] w_n_abs;
    logic [WIDTH-1:0]   w_d_abs;
    logic [WIDTH:0]     w_rs;
    logic [WIDTH-1:0]   w_diff;
    logic               w_ge;
    logic               w_range_err;
    logic [WIDTH-1:0]   w_q_fix, w_r_fix;

    assign w_start = r_exec_d & ~w_btn[0];

    always_comb begin
        w_n_abs = {r_a, r_b};
        w_d_abs = r_s;
`ifdef DIV_SIGNED_EN
        if (r_a[WIDTH-1]) w_n_abs = -{r_a, r_b};
        if (r_s[WIDTH-1]) w_d_abs = -r_s;
`endif
    end

    // Stored remainder is always < divisor, so only the shifted value needs the extra bit.
    assign w_rs   = {r_rem, r_quo[WIDTH-1]};
    assign w_ge   = (w_rs >= {1'b0, r_dabs});
    assign w_diff = w_rs[WIDTH-1:0] - r_dabs;

`ifdef DIV_SIGNED_EN
    logic w_qneg;
    assign w_qneg      = r_sn ^ r_sd;
    assign w_range_err = w_qneg ? (r_quo[WIDTH-1] & (|r_quo[WIDTH-2:0])) : r_quo[WIDTH-1];
    assign w_q_fix     = w_qneg ? -r_quo : r_quo;
    assign w_r_fix     = r_sn ? -r_rem : r_rem;
`else
    assign w_range_err = 1'b0;
    assign w_q_fix     = r_quo;
    assign w_r_fix     = r_rem;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_s      <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dabs   <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_ovf    <= 1'b0;
            r_exec_d <= 1'b1;
`ifdef DIV_SIGNED_EN
            r_sn     <= 1'b0;
            r_sd     <= 1'b0;
`endif
        end else begin
            r_exec_d <= w_btn[0];
            case (r_state)
                S_IDLE: begin
                    if (!w_btn[1]) r_a <= Din;
                    if (!w_btn[2]) r_b <= Din;
                    if (!w_btn[3]) r_s <= Din;
                    if (w_start) begin
                        r_busy  <= 1'b1;
                        r_state <= S_PREP;
                    end
                end
                S_PREP: begin
`ifdef DIV_SIGNED_EN
                    r_sn <= r_a[WIDTH-1];
                    r_sd <= r_s[WIDTH-1];
`endif
                    if (w_n_abs[2*WIDTH-1:WIDTH] >= w_d_abs) begin
                        r_ovf   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_ovf   <= 1'b0;
                        r_rem   <= w_n_abs[2*WIDTH-1:WIDTH];
                        r_quo   <= w_n_abs[WIDTH-1:0];
                        r_dabs  <= w_d_abs;
                        r_cnt   <= '0;
                        r_state <= S_ITER;
                    end
                end
                S_ITER: begin
                    r_rem <= w_ge ? w_diff : w_rs[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], w_ge};
                    if (r_cnt == c_LAST) r_state <= S_FIX;
                    else                 r_cnt   <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    if (w_range_err) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_a <= w_r_fix;
                        r_b <= w_q_fix;
                    end
                    r_busy  <= 1'b0;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    if (w_btn[0]) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    function automatic logic [6:0] f_seg7(input logic [3:0] v);
        case (v)
            4'h0: f_seg7 = 7'b1000000;
            4'h1: f_seg7 = 7'b1111001;
            4'h2: f_seg7 = 7'b0100100;
            4'h3: f_seg7 = 7'b0110000;
            4'h4: f_seg7 = 7'b0011001;
            4'h5: f_seg7 = 7'b0010010;
            4'h6: f_seg7 = 7'b0000010;
            4'h7: f_seg7 = 7'b1111000;
            4'h8: f_seg7 = 7'b0000000;
            4'h9: f_seg7 = 7'b0010000;
            4'hA: f_seg7 = 7'b0001000;
            4'hB: f_seg7 = 7'b0000011;
            4'hC: f_seg7 = 7'b1000110;
            4'hD: f_seg7 = 7'b0100001;
            4'hE: f_seg7 = 7'b0000110;
            default: f_seg7 = 7'b0001110;
        endcase
    endfunction

    logic [c_HW-1:0] w_a_ext, w_b_ext;
    assign w_a_ext = c_HW'(r_a);
    assign w_b_ext = c_HW'(r_b);

    assign AhexL = f_seg7(w_a_ext[3:0]);
    assign AhexU = f_seg7(w_a_ext[7:4]);
    assign BhexL = f_seg7(w_b_ext[3:0]);
    assign BhexU = f_seg7(w_b_ext[7:4]);

    assign Aval = r_a;
    assign Bval = r_b;
    assign Sval = r_s;
    assign Busy = r_busy;
    assign Ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_divider_processor.sv
`default_nettype none
// ============================================================================
// Module   : tb_divider_processor
// Desc     : Scoreboard bench for divider_processor against an arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_divider_processor;

    logic       Clk     = 1'b0;
    logic       Reset   = 1'b1;
    logic       Execute = 1'b1;
    logic       LoadA   = 1'b1;
    logic       LoadB   = 1'b1;
    logic       LoadS   = 1'b1;
    logic [7:0] Din     = 8'h00;
    logic [7:0] Aval, Bval, Sval;
    logic       Busy, Ovf;
    logic [6:0] AhexL, AhexU, BhexL, BhexU;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
        logic       ovf;
        int         busy;
    } exp_t;

    exp_t sb[$];

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    divider_processor #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .Clk(Clk), .Reset(Reset), .Execute(Execute),
        .LoadA(LoadA), .LoadB(LoadB), .LoadS(LoadS), .Din(Din),
        .Aval(Aval), .Bval(Bval), .Sval(Sval), .Busy(Busy), .Ovf(Ovf),
        .AhexL(AhexL), .AhexU(AhexU), .BhexL(BhexL), .BhexU(BhexU)
    );

    always #10 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Division as plain integer arithmetic; C-style / and % truncate toward zero.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [7:0] s);
        exp_t e;
        int   n, d, an, ad, q, r;
        e.a = a; e.b = b; e.s = s; e.ovf = 1'b0; e.busy = 10;
`ifdef DIV_SIGNED_EN
        n = int'($signed({a, b}));
        d = int'($signed(s));
`else
        n = int'({a, b});
        d = int'(s);
`endif
        an = (n < 0) ? -n : n;
        ad = (d < 0) ? -d : d;
        if ((an / 256) >= ad) begin
            e.ovf  = 1'b1;
            e.busy = 1;
            return e;
        end
        q = n / d;
        r = n % d;
`ifdef DIV_SIGNED_EN
        if (q > 127 || q < -128) begin
            e.ovf = 1'b1;
            return e;
        end
`endif
        e.a = r[7:0];
        e.b = q[7:0];
        return e;
    endfunction

    // Monitor: a completed run is a Busy pulse ending while out of reset.
    initial begin : monitor
        int   cnt;
        exp_t e;
        cnt = 0;
        forever begin
            @(negedge Clk);
            if (!Reset) begin
                cnt = 0;
            end else if (Busy) begin
                cnt++;
            end else if (cnt > 0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_run: got a %0d-cycle run, expected none", cnt);
                end else begin
                    e = sb.pop_front();
                    chk("busy_cycles", cnt, e.busy);
                    chk("A", Aval, e.a);
                    chk("B", Bval, e.b);
                    chk("S", Sval, e.s);
                    chk("Ovf", Ovf, e.ovf);
                    chk("hex", {AhexU, AhexL, BhexU, BhexL},
                        {seg_tab[e.a[7:4]], seg_tab[e.a[3:0]], seg_tab[e.b[7:4]], seg_tab[e.b[3:0]]});
                end
                cnt = 0;
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic load(input int which, input logic [7:0] v);
        Din = v;
        case (which)
            0:       LoadA = 1'b0;
            1:       LoadB = 1'b0;
            default: LoadS = 1'b0;
        endcase
        wait_cycles(3);
        LoadA = 1'b1; LoadB = 1'b1; LoadS = 1'b1;
        wait_cycles(3);
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (sb.size() > 0 && i < 60) begin
            @(negedge Clk);
            i++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d results pending, expected 0", sb.size());
            sb.delete();
        end
        wait_cycles(4);
    endtask

    task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [7:0] s);
        load(0, a);
        load(1, b);
        load(2, s);
        sb.push_back(model(a, b, s));
        Execute = 1'b0;
        wait_cycles(3);
        Execute = 1'b1;
        drain();
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_A"}, Aval, 8'h00);
        chk({tag, "_B"}, Bval, 8'h00);
        chk({tag, "_S"}, Sval, 8'h00);
        chk({tag, "_Busy"}, Busy, 1'b0);
        chk({tag, "_Ovf"}, Ovf, 1'b0);
        chk({tag, "_hex"}, {AhexU, AhexL, BhexU, BhexL}, {7'h40, 7'h40, 7'h40, 7'h40});
    endtask

    logic [7:0] ra, rb, rs;

    initial begin
        #5 Reset = 1'b0;
        wait_cycles(3);
        #1 check_cleared("reset");
        @(negedge Clk);
        Reset = 1'b1;
        wait_cycles(3);

        run(8'hFE, 8'h63, 8'h07);
        run(8'hFE, 8'h60, 8'h07);
        run(8'h00, 8'h10, 8'h00);
        run(8'h01, 8'h00, 8'h01);
        run(8'h00, 8'hFF, 8'h01);
        run(8'hFF, 8'h80, 8'hFF);
        run(8'hFF, 8'h80, 8'h01);
        run(8'h80, 8'h00, 8'h80);
        run(8'h00, 8'h00, 8'h05);

        for (int k = 0; k < 80; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 8'($urandom);
            if (k % 2 == 0) ra = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
            if (k % 7 == 0) rs = 8'h00;
            run(ra, rb, rs);
        end

        // Held Execute with a LoadS pulse mid-run: one division, S untouched.
        load(0, 8'h00);
        load(1, 8'h64);
        load(2, 8'h05);
        sb.push_back(model(8'h00, 8'h64, 8'h05));
        Execute = 1'b0;
        wait_cycles(5);
        Din   = 8'h03;
        LoadS = 1'b0;
        wait_cycles(2);
        LoadS = 1'b1;
        wait_cycles(3);
        Din = 8'h00;
        wait_cycles(30);
        Execute = 1'b1;
        drain();
        chk("held_S", Sval, 8'h05);

        // Asynchronous reset during the fifth ITER cycle.
        load(0, 8'h00);
        load(1, 8'h64);
        load(2, 8'h05);
        sb.push_back(model(8'h00, 8'h64, 8'h05));
        Execute = 1'b0;
        for (int i = 0; i < 20 && !Busy; i++) @(negedge Clk);
        chk("midop_busy_seen", Busy, 1'b1);
        wait_cycles(5);
        sb.delete();
        #1 Reset = 1'b0;
        #1 check_cleared("midop");
        Execute = 1'b1;
        wait_cycles(2);
        Reset = 1'b1;
        wait_cycles(4);
        run(8'hFE, 8'h63, 8'h07);
        run(8'h00, 8'h64, 8'h05);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/divider_processor.md
Name: divider_processor

Overview:
- Sequential shift-subtract divider; the inverse of the team's 8-bit add-shift multiplier processor.
- Operand and result registers are A (upper dividend / remainder), B (lower dividend / quotient) and S (divisor), all loaded from the Din switches.
- Computes A:B / S in place: quotient into B, remainder into A.
- Drives four hex displays with A and B, plus Busy and Ovf status; board-level top for a lab FPGA.

Parameters:
- WIDTH, 8, operand width; hex outputs valid only for 8.
- SYNC_STAGES, 2, synchronizer depth for the pushbutton inputs Execute, LoadA, LoadB, LoadS.

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset  in  1  asynchronous, active-low reset; clears all state immediately
- Execute  in  1  active-low pushbutton; starts one division
- LoadA  in  1  active-low; A <= Din
- LoadB  in  1  active-low; B <= Din
- LoadS  in  1  active-low; S <= Din
- Din  in  WIDTH  switch operand
- Aval  out  WIDTH  register A (remainder after a run)
- Bval  out  WIDTH  register B (quotient after a run)
- Sval  out  WIDTH  register S
- Busy  out  1  high while division is in progress
- Ovf  out  1  set on divide-by-zero or quotient out of range
- AhexL, AhexU, BhexL, BhexU  out  7  active-low 7-segment encodings of A and B nibbles

Behaviour:
- Reset low: A=B=S=0, Ovf=0, Busy=0, FSM=IDLE, synchronizers cleared, hex outputs 7'b1000000 ('0'). Takes effect without a clock edge, including mid-division.
- All pushbuttons pass through SYNC_STAGES flops. Cycle counts below are measured from the synchronized signal.
- Loads:
  - Level-sensitive; only accepted in IDLE, ignored otherwise.
  - Multiple loads asserted together all take effect in the same cycle.
- FSM states: IDLE -> PREP -> ITER (WIDTH cycles) -> FIX -> DONE -> IDLE.
- IDLE: start on the falling edge of synchronized Execute. Busy=1 from the next cycle.
- PREP (1 cycle):
  - Form |N| from A:B as a 2*WIDTH-bit value and |D| from S.
  - Record signs sN = A[MSB] and sD = S[MSB].
  - If |N|[2W-1:W] >= |D| (this covers S=0): set Ovf=1, leave A and B unchanged, go to DONE.
  - Otherwise clear Ovf and load the working register R:Q (R is WIDTH+1 bits).
- ITER (one bit per cycle, exactly WIDTH cycles):
  - Shift R:Q left by 1.
  - If R >= |D|: R -= |D| and Q[0] = 1; else Q[0] = 0.
  - Counter runs 0..WIDTH-1 with no wrap or reuse.
- FIX (1 cycle):
  - Quotient sign is sN^sD; remainder takes sign sN (truncation toward zero).
  - Range check: positive quotient must be <= 2^(W-1)-1, negative quotient magnitude <= 2^(W-1). On violation set Ovf=1 and leave A and B unchanged.
  - Otherwise B <= signed quotient, A <= signed remainder.
- DONE: Busy=0. Wait for synchronized Execute high, then go to IDLE. Holding Execute gives exactly one run.
- Latency: results on Aval/Bval valid 1+W+1 = 10 cycles after the start edge (8-bit). Busy is high for exactly those 10 cycles; an early overflow in PREP gives 1 cycle.
- Loads and Execute presses during Busy are ignored.
- S is never modified by a run.

Optional Feature:
- DIV_SIGNED_EN
  - Defined: two's-complement signed operation as above.
  - Undefined:
    - Operands are unsigned; no PREP sign conversion and no FIX sign fix.
    - FIX performs only the write-back; Ovf comes only from the PREP check.
    - FSM state sequence and latency are identical in both modes.

Test Plan:
- Signed: load A=0xFE, B=0x63, S=0x07, press Execute -> after 10 cycles B=0xC5 (-59), A=0x00, Ovf=0; BhexU/BhexL show C/5.
- Signed remainder sign: A:B=0xFE60 (-416), S=0x07 -> B=0xC5 (-59), A=0xFD (-3), Ovf=0.
- Divide-by-zero: S=0x00, A:B=0x0010 -> Ovf=1, A=0x00 and B=0x10 unchanged, Busy high for 1 cycle.
- Range overflow (signed): A:B=0x0100 (256), S=0x01 -> Ovf=1, A and B unchanged. Without DIV_SIGNED_EN, A:B=0x00FF, S=0x01 -> B=0xFF, A=0x00, Ovf=0.
- Held Execute and ignored loads: hold Execute low for 40 cycles while pulsing LoadS with Din=0x03 mid-run -> exactly one division, S unchanged.
- Reset mid-op: drive Reset low during ITER cycle 4 -> all outputs zero immediately, FSM in IDLE, a following normal run is correct.
